stepper_move_sequencer: RTL and testbench

//  Queues motion commands (direction, step count, dwell) and sequences the four-phase stepper
//  PWM driver: one move at a time, each started with a 1-clk start/load pulse, timed to

---
 rtl/stepper_move_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_stepper_move_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_move_sequencer.sv
// stepper_move_sequencer
//   Queues motion commands (direction, step count, dwell) in a small FIFO and
//   sequences a four-phase stepper PWM driver, one move at a time:
//   IDLE -> LOAD (1-clk drv_start) -> RUN ((cycles+1)*CLKS_PER_STEP clks)
//   -> DWELL (dwell clks, skipped when 0) -> IDLE with a 1-clk move_done.
//
// Optional feature macro: STEP_SEQ_ABORT_EN (adds the abort input: stop the
//   current move and flush the FIFO on the next edge).
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   abort             (STEP_SEQ_ABORT_EN only) stop current move, flush FIFO
//   cmd_valid/ready   command handshake, ready = FIFO not full
//   cmd_dir           1 = forward, 0 = reverse
//   cmd_cycles        move runs cmd_cycles+1 steps
//   cmd_dwell         idle clocks after the move ends
//   drv_start         1-clk pulse, driver latches drv_dir/drv_cycles
//   drv_dir/cycles    move parameters to the driver, change only on a pop
//   drv_hold          1 = downstream forces coil outputs to 0
//   busy              a move is in progress or commands are queued
//   move_done         1-clk pulse at the end of each move (after dwell)
//   fifo_level        number of queued commands
module stepper_move_sequencer #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CYCLES_W      = 10,
  parameter int unsigned DWELL_W       = 16,
  parameter int unsigned CLKS_PER_STEP = 2304
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef STEP_SEQ_ABORT_EN
  input  logic                          abort,
`endif
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_dir,
  input  logic [CYCLES_W-1:0]           cmd_cycles,
  input  logic [DWELL_W-1:0]            cmd_dwell,
  output logic                          drv_start,
  output logic                          drv_dir,
  output logic [CYCLES_W-1:0]           drv_cycles,
  output logic                          drv_hold,
  output logic                          busy,
  output logic                          move_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned KW = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(CLKS_PER_STEP - 1);

  typedef struct packed {
    logic                dir;
    logic [CYCLES_W-1:0] cycles;
    logic [DWELL_W-1:0]  dwell;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DWELL} state_t;

  cmd_t                r_fifo [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic                r_cmd_ready, r_busy;

  state_t              r_state;
  logic                r_drv_start, r_drv_dir, r_drv_hold, r_move_done;
  logic [CYCLES_W-1:0] r_drv_cycles, r_scnt;
  logic [DWELL_W-1:0]  r_mv_dwell, r_dcnt;
  logic [KW-1:0]       r_ccnt;

  logic                w_abort, w_push, w_pop, w_run_end, w_dwell_end, w_active_nxt;
  logic [LW-1:0]       w_level_nxt;
  cmd_t                w_head, w_cmd_in;

`ifdef STEP_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Abort outranks both push and pop; pops only happen from IDLE.
  assign w_push      = cmd_valid && r_cmd_ready && !w_abort;
  assign w_pop       = (r_state == S_IDLE) && (r_level != '0) && !w_abort;
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_cmd_in    = '{dir: cmd_dir, cycles: cmd_cycles, dwell: cmd_dwell};
  assign w_run_end   = (r_state == S_RUN) && (r_ccnt == K_LAST) && (r_scnt == r_drv_cycles);
  assign w_dwell_end = (r_state == S_DWELL) && (r_dcnt == r_mv_dwell - DWELL_W'(1));

  // FIFO occupancy after this edge.
  always_comb begin
    w_level_nxt = r_level;
    if (w_abort)              w_level_nxt = '0;
    else if (w_push && !w_pop) w_level_nxt = r_level + LW'(1);
    else if (!w_push && w_pop) w_level_nxt = r_level - LW'(1);
  end

  // FSM is outside IDLE after this edge (feeds the registered busy).
  always_comb begin
    w_active_nxt = 1'b0;
    case (r_state)
      S_IDLE:  w_active_nxt = w_pop;
      S_LOAD:  w_active_nxt = 1'b1;
      S_RUN:   w_active_nxt = !(w_run_end && (r_mv_dwell == '0));
      S_DWELL: w_active_nxt = !w_dwell_end;
      default: w_active_nxt = 1'b0;
    endcase
    if (w_abort) w_active_nxt = 1'b0;
  end

  // Command FIFO with registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_fifo[i] <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      if (w_abort) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_fifo[r_wr_ptr] <= w_cmd_in;
          r_wr_ptr         <= r_wr_ptr + AW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level     <= w_level_nxt;
      r_cmd_ready <= !w_abort && (w_level_nxt != LW'(FIFO_DEPTH));
      r_busy      <= w_active_nxt || (w_level_nxt != '0);
    end
  end

  // Move sequencer; outputs take effect on the edge that leaves a state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_drv_start  <= 1'b0;
      r_drv_dir    <= 1'b0;
      r_drv_cycles <= '0;
      r_drv_hold   <= 1'b1;
      r_move_done  <= 1'b0;
      r_mv_dwell   <= '0;
      r_ccnt       <= '0;
      r_scnt       <= '0;
      r_dcnt       <= '0;
    end else begin
      r_drv_start <= 1'b0;
      r_move_done <= 1'b0;
      if (w_abort) begin
        r_state    <= S_IDLE;
        r_drv_hold <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_pop) begin
              r_drv_dir    <= w_head.dir;
              r_drv_cycles <= w_head.cycles;
              r_mv_dwell   <= w_head.dwell;
              r_state      <= S_LOAD;
            end
          end
          S_LOAD: begin
            r_drv_start <= 1'b1;
            r_drv_hold  <= 1'b0;
            r_ccnt      <= '0;
            r_scnt      <= '0;
            r_state     <= S_RUN;
          end
          S_RUN: begin
            if (r_ccnt == K_LAST) begin
              r_ccnt <= '0;
              if (w_run_end) begin
                r_drv_hold <= 1'b1;
                r_dcnt     <= '0;
                if (r_mv_dwell == '0) begin
                  r_move_done <= 1'b1;
                  r_state     <= S_IDLE;
                end else begin
                  r_state <= S_DWELL;
                end
              end else begin
                r_scnt <= r_scnt + CYCLES_W'(1);
              end
            end else begin
              r_ccnt <= r_ccnt + KW'(1);
            end
          end
          S_DWELL: begin
            if (w_dwell_end) begin
              r_move_done <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_dcnt <= r_dcnt + DWELL_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign busy       = r_busy;
  assign fifo_level = r_level;
  assign drv_start  = r_drv_start;
  assign drv_dir    = r_drv_dir;
  assign drv_cycles = r_drv_cycles;
  assign drv_hold   = r_drv_hold;
  assign move_done  = r_move_done;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Bench for stepper_move_sequencer: directed scenarios plus randomized command
// traffic, compared every clock against a time-stamp model of each move.
module tb_stepper_move_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 10;
  localparam int unsigned DW    = 16;
  localparam int unsigned CPS   = 2304;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_cycles = '0;
  logic [DW-1:0] cmd_dwell = '0;
  logic          cmd_ready, drv_start, drv_dir, drv_hold, busy, move_done;
  logic [CW-1:0] drv_cycles;
  logic [2:0]    fifo_level;
`ifdef STEP_SEQ_ABORT_EN
  logic          abort = 1'b0;
`endif

  stepper_move_sequencer #(
    .FIFO_DEPTH(DEPTH), .CYCLES_W(CW), .DWELL_W(DW), .CLKS_PER_STEP(CPS)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef STEP_SEQ_ABORT_EN
    .abort(abort),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_cycles(cmd_cycles), .cmd_dwell(cmd_dwell),
    .drv_start(drv_start), .drv_dir(drv_dir), .drv_cycles(drv_cycles),
    .drv_hold(drv_hold), .busy(busy), .move_done(move_done), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] pack(input logic s, h, d, b, r, input logic [2:0] l,
                                       input logic dr, input logic [CW-1:0] cy);
    return {s, h, d, b, r, l, dr, cy};
  endfunction

  function automatic bit abort_now();
`ifdef STEP_SEQ_ABORT_EN
    return abort;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: each popped move is described by the edge numbers at
  // which its start pulse, hold release, hold return and completion occur.
  typedef struct { bit dir; int cyc; int dwl; } mcmd_t;
  mcmd_t  q[$];
  longint k = 0;
  longint pop_e, start_e, run_end_e, done_e;
  bit     armed, m_ready, m_dir;
  int     m_cyc;
  bit     e_start, e_hold, e_done, e_busy;
  int     e_level;

  task automatic model_reset();
    q.delete();
    armed = 0; pop_e = -1; start_e = -1; run_end_e = -1; done_e = -1;
    m_ready = 1; m_dir = 0; m_cyc = 0;
    e_start = 0; e_hold = 1; e_done = 0; e_busy = 0; e_level = 0;
  endtask

  function automatic bit pop_next();
    return (!armed || (k + 1 > done_e)) && (q.size() > 0) && !abort_now();
  endfunction

  task automatic model_edge();
    bit    ab;
    mcmd_t c;
    k++;
    ab = abort_now();
    if (ab) begin
      q.delete();
      armed = 0; start_e = -1; run_end_e = -1;
    end else begin
      if ((!armed || k > done_e) && q.size() > 0) begin
        c = q.pop_front();
        m_dir = c.dir; m_cyc = c.cyc;
        pop_e     = k;
        start_e   = k + 1;
        run_end_e = start_e + longint'(c.cyc + 1) * longint'(CPS);
        done_e    = run_end_e + longint'(c.dwl);
        armed     = 1;
      end
      if (cmd_valid && m_ready) begin
        c.dir = cmd_dir; c.cyc = int'(cmd_cycles); c.dwl = int'(cmd_dwell);
        q.push_back(c);
      end
    end
    e_level = q.size();
    m_ready = !ab && (e_level != int'(DEPTH));
    e_start = (k == start_e);
    e_hold  = !(k >= start_e && k < run_end_e);
    e_done  = armed && (k == done_e);
    e_busy  = (armed && k >= pop_e && k < done_e) || (e_level != 0);
  endtask

  // Observations of the DUT used by the directed checks.
  longint start_k, prev_start_k, hold_rise_k, done_k, busy_fall_k;
  int     starts, dones, hold_low;
  bit     prev_hold = 1, prev_busy = 0;
  bit     dirs[$];

  task automatic clr_obs();
    start_k = 0; prev_start_k = 0; hold_rise_k = 0; done_k = 0; busy_fall_k = 0;
    starts = 0; dones = 0; hold_low = 0;
    dirs.delete();
  endtask

  task automatic step_cycle();
    logic [18:0] act, exp;
    @(posedge clk);
    model_edge();
    #1;
    act = pack(drv_start, drv_hold, move_done, busy, cmd_ready, fifo_level, drv_dir, drv_cycles);
    exp = pack(e_start, e_hold, e_done, e_busy, m_ready, 3'(e_level), m_dir, CW'(m_cyc));
    if (n_bad < 40) chk("cycle", act, exp);
    if (drv_start) begin prev_start_k = start_k; start_k = k; starts++; dirs.push_back(drv_dir); end
    if (!drv_hold) hold_low++;
    if (drv_hold && !prev_hold) hold_rise_k = k;
    if (!busy && prev_busy) busy_fall_k = k;
    if (move_done) begin done_k = k; dones++; end
    prev_hold = drv_hold;
    prev_busy = busy;
  endtask

  task automatic run(input int n);
    repeat (n) step_cycle();
  endtask

  task automatic push(input bit d, input int c, input int w);
    cmd_valid = 1; cmd_dir = d; cmd_cycles = CW'(c); cmd_dwell = DW'(w);
    step_cycle();
    cmd_valid = 0;
  endtask

  task automatic drain(input int budget);
    int i = 0;
    while (e_busy && i < budget) begin step_cycle(); i++; end
    chk("drain_busy", busy, 0);
  endtask

  logic [18:0] rst_vec;
  longint      push_k;
  bit          exp_dirs [5];

  initial begin
    rst_vec = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, '0);
    model_reset();
    clr_obs();
    #12;
    chk("reset_outs", pack(drv_start, drv_hold, move_done, busy, cmd_ready, fifo_level, drv_dir, drv_cycles), rst_vec);
    #10 rst = 0;
    run(3);

    // Single move with dwell.
    clr_obs();
    push(1, 3, 10); push_k = k;
    drain(12000);
    chk("t1_start_lat", start_k - push_k, 2);
    chk("t1_hold_low", hold_low, 4 * CPS);
    chk("t1_done_after_hold", done_k - hold_rise_k, 10);
    chk("t1_busy_fall", busy_fall_k, done_k);
    chk("t1_dones", dones, 1);

    // Back-to-back one-step moves: RUN, then one IDLE (pop) and one LOAD cycle.
    clr_obs();
    push(0, 0, 0);
    push(1, 0, 0);
    drain(8000);
    chk("t3_starts", starts, 2);
    chk("t3_gap", start_k - prev_start_k, CPS + 2);
    chk("t3_hold_low", hold_low, 2 * CPS);

    // Fill the FIFO behind a running move; a fifth offer is refused.
    clr_obs();
    push(1, 0, 5);
    run(2);
    push(0, 0, 3); push(1, 0, 0); push(0, 0, 7); push(1, 0, 2);
    chk("t2_level_full", fifo_level, 4);
    chk("t2_ready_full", cmd_ready, 0);
    cmd_valid = 1; cmd_dir = 0; cmd_cycles = CW'(1); cmd_dwell = DW'(1);
    step_cycle();
    cmd_valid = 0;
    chk("t2_level_hold", fifo_level, 4);
    drain(20000);
    chk("t2_moves", starts, 5);
    exp_dirs = '{1, 0, 1, 0, 1};
    for (int i = 0; i < 5; i++) chk("t2_dir_order", (i < dirs.size()) ? dirs[i] : 1'bx, exp_dirs[i]);

    // Push coinciding with a pop at level 2; pointers have wrapped by now.
    clr_obs();
    push(1, 0, 0);
    run(2);
    push(0, 1, 0);
    push(1, 0, 4);
    begin
      int i = 0;
      while (!pop_next() && i < 6000) begin step_cycle(); i++; end
    end
    cmd_valid = 1; cmd_dir = 0; cmd_cycles = CW'(0); cmd_dwell = DW'(2);
    step_cycle();
    cmd_valid = 0;
    chk("t4_level_pushpop", fifo_level, 2);
    drain(20000);
    chk("t4_moves", starts, 4);

    // Randomized command traffic.
    for (int r = 0; r < 5; r++) begin
      int n = $urandom_range(1, 2);
      for (int j = 0; j < n; j++) begin
        cmd_valid  = 1;
        cmd_dir    = 1'($urandom_range(0, 1));
        cmd_cycles = ($urandom_range(0, 3) == 0) ? CW'(1) : CW'(0);
        cmd_dwell  = ($urandom_range(0, 2) == 0) ? DW'(0) : DW'($urandom_range(1, 20));
        step_cycle();
        cmd_valid  = 0;
        run($urandom_range(0, 3));
      end
      run($urandom_range(0, 2500));
    end
    drain(40000);

    // Asynchronous reset in the middle of RUN.
    clr_obs();
    push(1, 2, 3);
    run(1000);
    #2 rst = 1;
    #1;
    chk("t5_async_reset", pack(drv_start, drv_hold, move_done, busy, cmd_ready, fifo_level, drv_dir, drv_cycles), rst_vec);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 0;
    model_reset();
    run(3000);
    chk("t5_no_done", dones, 0);
    chk("t5_level", fifo_level, 0);

`ifdef STEP_SEQ_ABORT_EN
    // Abort during RUN with three commands queued.
    clr_obs();
    push(1, 1, 5);
    run(2);
    push(0, 0, 1); push(1, 0, 1); push(0, 0, 1);
    run(500);
    abort = 1;
    step_cycle();
    chk("t6_level", fifo_level, 0);
    chk("t6_hold", drv_hold, 1);
    cmd_valid = 1;
    step_cycle();
    chk("t6_ready_held", cmd_ready, 0);
    cmd_valid = 0;
    abort = 0;
    run(50);
    chk("t6_no_done", dones, 0);
    chk("t6_level_after", fifo_level, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
